pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 23 ++
 rtl/pipe_stage_skid.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage-state type, default widths and control-bus bit indices
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_LOAD     = 3;
  localparam int CTRL_ERET     = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, sticks at all-ones instead of wrapping
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage register with skid entry and fully registered in_ready
// Optional PIPE_STAGE_PERF_EN builds the stall/flush saturating counters; otherwise they read 0.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_state_t      state_q;
  stage_state_t      state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic accept;
  logic deliver;
  logic load_main;
  logic load_skid;
  logic move_skid;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FULL;
        ST_FULL: begin
          if (accept && !deliver) begin
            state_d = ST_SKID;
          end else if (!accept && deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID:  if (deliver) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // A beat can only reach the skid entry while main is held, so in_ready drops a cycle late.
  always_comb begin
    out_valid = 1'b0;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: load_main = accept;
      ST_FULL: begin
        out_valid = 1'b1;
        load_main = accept && out_ready;
        load_skid = accept && !out_ready;
      end
      ST_SKID: begin
        out_valid = 1'b1;
        move_skid = out_ready;
      end
      default: out_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (move_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = main_data_q;
  assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid && !out_ready;
  // Counts a flush that discarded a held beat or one being accepted in that same cycle.
  assign flush_inc = flush && (out_valid || accept);

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .clr  (1'b0),
    .cnt  (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_inc),
    .clr  (1'b0),
    .cnt  (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed bench for pipe_stage_skid with hand-computed expectations
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] perf_exp(input logic [63:0] v);
    return PERF ? v : 64'd0;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // 1: reset with in_valid held high
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA5;
    in_ctrl   = 8'h01;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end
    check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    check("rst_flush_cnt", {60'd0, flush_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);
    check("rel_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_data", out_data, 64'hA5);
    check("first_ctrl", {56'd0, out_ctrl}, 64'h01);
    in_valid = 1'b0;
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_ctrl", {56'd0, out_ctrl}, 64'd0);

    // 2: streaming at one beat per cycle
    in_valid = 1'b1;
    in_ctrl  = 8'h01;
    for (int i = 0; i < 16; i++) begin
      in_data = 64'(i);
      tick();
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_data", out_data, 64'(i));
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", {63'd0, out_valid}, 64'd0);
    check("stream_end_ctrl", {56'd0, out_ctrl}, 64'd0);

    // 3: second beat lands in skid while downstream stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h10;
    tick();
    check("skid_main", out_data, 64'h10);
    check("skid_rdy_full", {63'd0, in_ready}, 64'd1);
    in_data = 64'h11;
    tick();
    check("skid_rdy_low", {63'd0, in_ready}, 64'd0);
    check("skid_hold", out_data, 64'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("skid_second", out_data, 64'h11);
    check("skid_second_vld", {63'd0, out_valid}, 64'd1);
    check("skid_rdy_back", {63'd0, in_ready}, 64'd1);
    tick();
    check("skid_empty", {63'd0, out_valid}, 64'd0);

    // 4: flush in SKID with an incoming beat, then flush while accepting in FULL
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h01;
    in_data   = 64'h30;
    tick();
    in_data = 64'h31;
    tick();
    check("fl_pre_rdy", {63'd0, in_ready}, 64'd0);
    flush   = 1'b1;
    in_data = 64'h22;
    in_ctrl = 8'h03;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("fl_data", out_data, 64'd0);
    check("fl_rdy", {63'd0, in_ready}, 64'd1);
    check("fl_cnt1", {60'd0, flush_cnt}, perf_exp(64'd1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_22", {63'd0, out_valid}, 64'd0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h40;
    tick();
    flush   = 1'b1;
    in_data = 64'h41;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_full_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("fl_full_gone", {63'd0, out_valid}, 64'd0);
    check("fl_cnt2", {60'd0, flush_cnt}, perf_exp(64'd2));

    // 5: five-cycle stall keeps outputs bit-stable
    do_reset();
    check("st_rst_cnt", {60'd0, stall_cnt}, 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 8'h02;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_data", out_data, 64'h55);
      check("st_ctrl", {56'd0, out_ctrl}, 64'h02);
    end
    check("st_cnt5", {60'd0, stall_cnt}, perf_exp(64'd5));
    out_ready = 1'b1;
    tick();
    check("st_cnt_keep", {60'd0, stall_cnt}, perf_exp(64'd5));
    check("st_done", {63'd0, out_valid}, 64'd0);

    // 6: counter saturation with a 4-bit counter, then a single killing flush
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h66;
    in_ctrl   = 8'h01;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_f", {60'd0, stall_cnt}, perf_exp(64'hF));
    for (int i = 0; i < 3; i++) tick();
    check("sat_hold", {60'd0, stall_cnt}, perf_exp(64'hF));
    check("sat_fl0", {60'd0, flush_cnt}, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_fl1", {60'd0, flush_cnt}, perf_exp(64'd1));
    check("sat_fl_valid", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
